pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Frame-rate game sequencer for Pong. Owns ball position/velocity, both paddle positions and
//  both life counters; drives the ball, paddle and lives inputs of the VGA image renderer.
//  All state advances once per video frame on frame_tick, so the renderer never sees mid-frame motion.
// PARAMETERS
//  BALL_SZ     12   ball square side, px
//  PAD_LEN     100  paddle height, px
//  PAD_LX      30   left paddle left edge x (paddle spans PAD_LX..PAD_LX+10)
//  PAD_RX      600  right paddle left edge x (spans PAD_RX..PAD_RX+10)
//  TOP_Y       10   playfield top (bottom of HUD strip)
//  BOT_Y       470  playfield bottom (top of bottom wall)
//  L_WALL      10   left goal line x;  R_WALL 630 right goal line x
//  BALL_STEP   2    ball px/frame per axis
//  PAD_STEP    4    paddle px/frame
//  LIVES_INIT  7    lives per player at game start (3-bit, 1..7)
//  SERVE_FR    60   frames ball is held centred before play
// PORTS
//  clk         in   1   pixel clock
//  reset       in   1   asynchronous, active-high
//  frame_tick  in   1   1-cycle pulse per frame (start of vertical blank)
//  start       in   1   level; begins game from IDLE / returns from GAMEOVER
//  l_up,l_dn   in   1   left player buttons (synchronised upstream)
//  r_up,r_dn   in   1   right player buttons
//  posx,posy   out  10  ball top-left corner
//  posbarraiy  out  10  left paddle top y
//  posbarrady  out  10  right paddle top y
//  vidasi      out  3   left lives;  vidasd out 3 right lives
//  game_over   out  1   high in GAMEOVER;  winner out 1 (0=left,1=right), valid when game_over
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, posx=314, posy=234, paddles=190, lives=LIVES_INIT,
//   dx=+1 (right), dy=+1 (down), serve counter=0, game_over=0, winner=0.
//  All outputs registered; updates take effect the cycle after frame_tick; no change otherwise.
//  FSM: IDLE -start-> SERVE; SERVE: ball at 314,234, count SERVE_FR ticks -> PLAY;
//   PLAY: ball moves, point detected -> POINT; POINT (1 tick): decrement loser's lives;
//   if result 0 -> GAMEOVER (winner = other player) else -> SERVE, dx toward loser.
//   GAMEOVER: everything frozen; start -> IDLE with lives/paddles/ball re-initialised.
//  Ball per tick in PLAY: nx=posx±BALL_STEP, ny=posy±BALL_STEP; compute in 11-bit signed, no wrap.
//   ny<=TOP_Y -> posy=TOP_Y, dy=+; ny+BALL_SZ>=BOT_Y -> posy=BOT_Y-BALL_SZ, dy=-.
//   dx<0, nx<=PAD_LX+10, nx+BALL_SZ>PAD_LX, y-overlap with left paddle -> posx=PAD_LX+11, dx=+.
//   dx>0, nx+BALL_SZ>=PAD_RX, nx<PAD_RX+10, y-overlap right paddle -> posx=PAD_RX-BALL_SZ-1, dx=-.
//   else nx<=L_WALL -> left loses point; nx+BALL_SZ>=R_WALL -> right loses point.
//   Corner: wall bounce and paddle bounce in same tick both apply. Paddle hit beats goal test.
//  Paddles move in SERVE and PLAY only: up -> -PAD_STEP, dn -> +PAD_STEP, both/none -> hold;
//   clamp to [TOP_Y, BOT_Y-PAD_LEN] = [10,370]; never wraps.
//  Lives saturate at 0; never decremented outside POINT. start ignored in SERVE/PLAY/POINT.
// STRUCTURE
//  pong_pkg: geometry localparams (screen, walls, paddle x, sizes), state encoding
//   {IDLE,SERVE,PLAY,POINT,GAMEOVER} (3-bit), reset positions.
//  Sub-module pad_ctrl (up,dn,en,tick -> 10-bit clamped y), instantiated twice.
//  Top holds FSM, serve counter (6-bit), ball registers/direction flags, life counters.
// TESTING
//  Reset mid-PLAY -> next cycle IDLE, posx=314, posy=234, pads=190, lives=7/7.
//  start, 60 ticks -> still SERVE at tick 59, PLAY after 60th; ball moves +2,+2 per tick only.
//  Ball forced posy=11, dy=-1 -> next tick posy=10, dy=+; at posy=457 dy=+ -> posy=458, dy=-.
//  Left paddle y=190, ball dx=- at x=42,y=200 -> posx=41, dx=+; paddle y=300 -> reaches x<=10,
//   vidasi 7->6, SERVE, serve dx=- .
//  l_up held from 10 -> stays 10; r_dn held -> stops at 370; l_up&l_dn -> no motion.
//  vidasd=1, right miss -> vidasd=0, game_over=1, winner=0; ticks freeze; start -> IDLE, lives 7/7.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared geometry, reset positions and FSM encoding for the Pong game sequencer.
package pong_pkg;

  typedef logic [9:0]        coord_t;
  typedef logic signed [10:0] scoord_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  // Ball-path geometry, signed so overshoot past a wall never wraps
  localparam scoord_t BALL_SZ   = 11'sd12;
  localparam scoord_t PAD_LEN   = 11'sd100;
  localparam scoord_t PAD_W     = 11'sd10;
  localparam scoord_t PAD_LX    = 11'sd30;
  localparam scoord_t PAD_RX    = 11'sd600;
  localparam scoord_t TOP_Y     = 11'sd10;
  localparam scoord_t BOT_Y     = 11'sd470;
  localparam scoord_t L_WALL    = 11'sd10;
  localparam scoord_t R_WALL    = 11'sd630;
  localparam scoord_t BALL_STEP = 11'sd2;

  // Paddle travel limits and reset positions
  localparam coord_t PAD_YMIN = 10'd10;
  localparam coord_t PAD_YMAX = 10'd370;
  localparam coord_t PAD_STEP = 10'd4;
  localparam coord_t PAD_Y0   = 10'd190;
  localparam coord_t BALL_X0  = 10'd314;
  localparam coord_t BALL_Y0  = 10'd234;

  localparam logic [2:0] LIVES_INIT = 3'd7;
  // Serve lasts 60 frames: counter runs 0..59
  localparam logic [5:0] SERVE_LAST = 6'd59;

  function automatic scoord_t to_s(input coord_t c);
    return $signed({1'b0, c});
  endfunction

  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

endpackage

// File: rtl/pad_ctrl.sv
// One paddle: frame-rate up/down motion clamped to the playfield.
module pad_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic       init_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [9:0] y_o
);

  coord_t y_q, y_d;

  // Next paddle position; both or no buttons hold position
  always_comb begin
    y_d = y_q;
    if (tick_i) begin
      if (init_i) begin
        y_d = PAD_Y0;
      end else if (en_i) begin
        if (up_i && !dn_i) begin
          y_d = (y_q <= PAD_YMIN + PAD_STEP) ? PAD_YMIN : y_q - PAD_STEP;
        end else if (dn_i && !up_i) begin
          y_d = (y_q >= PAD_YMAX - PAD_STEP) ? PAD_YMAX : y_q + PAD_STEP;
        end
      end
    end
  end

  // Paddle position register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= PAD_Y0;
    else       y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong frame-rate sequencer: game FSM, ball motion/collisions, lives, paddles.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [9:0] posbarraiy,
  output logic [9:0] posbarrady,
  output logic [2:0] vidasi,
  output logic [2:0] vidasd,
  output logic       game_over,
  output logic       winner
);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  coord_t     posx_q, posx_d, posy_q, posy_d;
  logic       dx_q, dx_d, dy_q, dy_d;       // 1 = right / down
  logic [2:0] vl_q, vl_d, vr_q, vr_d;
  logic       loser_q, loser_d;             // 1 = right player lost the point
  logic       go_q, go_d, win_q, win_d;

  coord_t     pad_l, pad_r;
  logic       pad_en, pad_init;

  scoord_t    nx, ny, x_new, y_new;
  logic       dx_new, dy_new, ovl_l, ovl_r, hit_l, hit_r, goal_l, goal_r;
  logic [2:0] lives_new;

  assign pad_en   = (state_q == ST_SERVE) || (state_q == ST_PLAY);
  assign pad_init = (state_q == ST_GAMEOVER) && start;

  pad_ctrl u_pad_l (
    .clk    (clk),
    .reset  (reset),
    .tick_i (frame_tick),
    .en_i   (pad_en),
    .init_i (pad_init),
    .up_i   (l_up),
    .dn_i   (l_dn),
    .y_o    (pad_l)
  );

  pad_ctrl u_pad_r (
    .clk    (clk),
    .reset  (reset),
    .tick_i (frame_tick),
    .en_i   (pad_en),
    .init_i (pad_init),
    .up_i   (r_up),
    .dn_i   (r_dn),
    .y_o    (pad_r)
  );

  // Candidate ball step: wall bounce first, then paddle hit, then goal test
  always_comb begin
    nx = dx_q ? to_s(posx_q) + BALL_STEP : to_s(posx_q) - BALL_STEP;
    ny = dy_q ? to_s(posy_q) + BALL_STEP : to_s(posy_q) - BALL_STEP;

    y_new  = ny;
    dy_new = dy_q;
    if (ny <= TOP_Y) begin
      y_new  = TOP_Y;
      dy_new = 1'b1;
    end else if (ny + BALL_SZ >= BOT_Y) begin
      y_new  = BOT_Y - BALL_SZ;
      dy_new = 1'b0;
    end

    // Overlap uses the wall-corrected y so a corner bounce still meets the paddle
    ovl_l = (y_new + BALL_SZ > to_s(pad_l)) && (y_new < to_s(pad_l) + PAD_LEN);
    ovl_r = (y_new + BALL_SZ > to_s(pad_r)) && (y_new < to_s(pad_r) + PAD_LEN);
    hit_l = !dx_q && (nx <= PAD_LX + PAD_W) && (nx + BALL_SZ > PAD_LX) && ovl_l;
    hit_r =  dx_q && (nx + BALL_SZ >= PAD_RX) && (nx < PAD_RX + PAD_W) && ovl_r;

    x_new  = nx;
    dx_new = dx_q;
    goal_l = 1'b0;
    goal_r = 1'b0;
    if (hit_l) begin
      x_new  = PAD_LX + PAD_W + 11'sd1;
      dx_new = 1'b1;
    end else if (hit_r) begin
      x_new  = PAD_RX - BALL_SZ - 11'sd1;
      dx_new = 1'b0;
    end else if (nx <= L_WALL) begin
      goal_l = 1'b1;
    end else if (nx + BALL_SZ >= R_WALL) begin
      goal_r = 1'b1;
    end
  end

  // Game FSM and per-frame state update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    posx_d    = posx_q;
    posy_d    = posy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    vl_d      = vl_q;
    vr_d      = vr_q;
    loser_d   = loser_q;
    go_d      = go_q;
    win_d     = win_q;
    lives_new = '0;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end
        end
        ST_SERVE: begin
          posx_d = BALL_X0;
          posy_d = BALL_Y0;
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_PLAY: begin
          posx_d = x_new[9:0];
          posy_d = y_new[9:0];
          dx_d   = dx_new;
          dy_d   = dy_new;
          if (goal_l || goal_r) begin
            state_d = ST_POINT;
            loser_d = goal_r;
          end
        end
        ST_POINT: begin
          lives_new = loser_q ? dec_sat(vr_q) : dec_sat(vl_q);
          if (loser_q) vr_d = lives_new;
          else         vl_d = lives_new;
          if (lives_new == 3'd0) begin
            state_d = ST_GAMEOVER;
            go_d    = 1'b1;
            win_d   = ~loser_q;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = '0;
            posx_d  = BALL_X0;
            posy_d  = BALL_Y0;
            dx_d    = loser_q;
          end
        end
        ST_GAMEOVER: begin
          if (start) begin
            state_d = ST_IDLE;
            go_d    = 1'b0;
            win_d   = 1'b0;
            vl_d    = LIVES_INIT;
            vr_d    = LIVES_INIT;
            posx_d  = BALL_X0;
            posy_d  = BALL_Y0;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      posx_q  <= BALL_X0;
      posy_q  <= BALL_Y0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      vl_q    <= LIVES_INIT;
      vr_q    <= LIVES_INIT;
      loser_q <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      vl_q    <= vl_d;
      vr_q    <= vr_d;
      loser_q <= loser_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end

  assign posx       = posx_q;
  assign posy       = posy_q;
  assign posbarraiy = pad_l;
  assign posbarrady = pad_r;
  assign vidasi     = vl_q;
  assign vidasd     = vr_q;
  assign game_over  = go_q;
  assign winner     = win_q;

endmodule
